// File: rtl/nuart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nuart_pkg
// Purpose  : Shared types and constants for the shared UART transmit
//            scheduler: shifter state encoding, frame data width, line idle
//            level and a parity helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package nuart_pkg;

  localparam int   DATA_BITS = 8;
  localparam int   CNT_W     = $clog2(DATA_BITS);
  localparam logic LINE_IDLE = 1'b1;

  // PARITY is only reachable when NUART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } shift_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage : nuart_pkg
`default_nettype wire

// File: rtl/nuart_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nuart_rr_arbiter
// Purpose  : Combinational round-robin pick. The winner is the first set bit
//            of valid scanning ptr, ptr+1, ... modulo NUM_REQ.
// Ports    : valid      in  NUM_REQ  request vector
//            ptr        in  IDX_W    highest-priority index (< NUM_REQ)
//            winner_oh  out NUM_REQ  one-hot winner (zero when none valid)
//            winner_idx out IDX_W    winner index (zero when none valid)
//            any_valid  out 1        at least one request is valid
// Revision : 1.0  initial release
// ============================================================================
module nuart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       offset;
  logic [IDX_W:0]       sum;

  always_comb begin
    // Rotating a doubled copy puts requester ptr at bit 0, so the lowest set
    // bit of rot is the distance from ptr to the winner.
    dbl       = {valid, valid};
    rot       = NUM_REQ'(dbl >> ptr);
    any_valid = |valid;
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = (IDX_W + 1)'(i);
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    winner_idx = any_valid ? sum[IDX_W-1:0] : '0;
    winner_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      winner_oh[k] = any_valid && (sum[IDX_W-1:0] == IDX_W'(k));
    end
  end

endmodule : nuart_rr_arbiter
`default_nettype wire

// File: rtl/nuart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nuart_tx_sched
// Purpose  : Shares one UART TX line among NUM_REQ requesters. Packets are
//            arbitrated round-robin and never interleaved; a one-byte hold
//            register in front of the shift register gives back-to-back
//            frames. Bits advance only on the tx_timing_i baud strobe.
//            Optional macro NUART_PARITY_EN inserts an even-parity bit
//            between data bit 7 and the stop bit(s).
// Ports    : clk_i        in  1          system clock
//            rst_i        in  1          synchronous active-high reset
//            tx_timing_i  in  1          one-cycle baud strobe
//            req_valid_i  in  NUM_REQ    per-requester byte valid
//            req_data_i   in  8*NUM_REQ  byte k at [8k+7:8k]
//            req_last_i   in  NUM_REQ    final byte of the packet
//            req_ready_o  out NUM_REQ    byte accepted when valid & ready
//            txd_o        out 1          serial line, idle high
//            grant_idx_o  out IDX_W      current/last packet owner
//            locked_o     out 1          multi-byte packet in progress
//            busy_o       out 1          hold full | shifter active | locked
// Revision : 1.0  initial release
// ============================================================================
module nuart_tx_sched
  import nuart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tx_timing_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   txd_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   locked_o,
  output logic                   busy_o
);

  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);

  // Shifter state
  shift_state_t           state_q, state_d;
  logic                   txd_q, txd_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   load;

  // Hold register and packet ownership
  logic [DATA_BITS-1:0]   hold_q;
  logic                   hold_full_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       ptr_q;
  logic                   locked_q;

  // Accept path
  logic [NUM_REQ-1:0]     win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any;
  logic [NUM_REQ-1:0]     owner_oh;
  logic [NUM_REQ-1:0]     ready;
  logic [IDX_W-1:0]       acc_idx;
  logic [IDX_W-1:0]       ptr_next;
  logic                   accept;
  logic [DATA_BITS-1:0]   acc_data;
  logic                   acc_last;

  nuart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid      (req_valid_i),
    .ptr        (ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any_valid  (win_any)
  );

  // --------------------------------------------------------------------------
  // Accept path: while locked only the owner may be readied; otherwise the
  // arbiter winner is. Nothing is readied while the hold register is full.
  // --------------------------------------------------------------------------
  always_comb begin
    owner_oh = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      owner_oh[k] = (owner_q == IDX_W'(k));
    end
    if (hold_full_q)   ready = '0;
    else if (locked_q) ready = owner_oh;
    else               ready = win_any ? win_oh : '0;
    acc_idx = locked_q ? owner_q : win_idx;
    accept  = |(ready & req_valid_i);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc_idx == IDX_W'(k)) begin
        acc_data = req_data_i[8*k +: 8];
        acc_last = req_last_i[k];
      end
    end
    ptr_next = (acc_idx == LAST_IDX) ? '0 : acc_idx + IDX_W'(1);
  end

  assign req_ready_o = ready;

  // --------------------------------------------------------------------------
  // Shifter next-state logic. Every transition is gated by the baud strobe,
  // and txd is registered so the line changes exactly on strobe edges.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;
    if (tx_timing_i) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            txd_d   = 1'b0;
            shift_d = hold_q;
            load    = 1'b1;
            state_d = ST_START;
          end
        end
        ST_START: begin
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q != LAST_BIT) begin
            txd_d     = shift_q[bit_cnt_q + CNT_W'(1)];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
`ifdef NUART_PARITY_EN
            txd_d      = even_parity(shift_q);
            state_d    = ST_PARITY;
`else
            txd_d      = LINE_IDLE;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
`endif
          end
        end
`ifdef NUART_PARITY_EN
        ST_PARITY: begin
          txd_d      = LINE_IDLE;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            // Reloading straight from STOP is what removes the idle bit
            // between consecutive frames.
            if (hold_full_q) begin
              txd_d   = 1'b0;
              shift_d = hold_q;
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          txd_d   = LINE_IDLE;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      txd_q      <= LINE_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Hold register and ownership. accept requires an empty hold while load
  // requires a full one, so the two never coincide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
      locked_q    <= 1'b0;
    end else begin
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_q      <= acc_data;
        hold_full_q <= 1'b1;
      end
      if (accept) begin
        owner_q  <= acc_idx;
        locked_q <= !acc_last;
        if (acc_last) ptr_q <= ptr_next;
      end
    end
  end

  assign txd_o       = txd_q;
  assign grant_idx_o = owner_q;
  assign locked_o    = locked_q;
  assign busy_o      = hold_full_q | (state_q != ST_IDLE) | locked_q;

endmodule : nuart_tx_sched
`default_nettype wire

// File: tb/tb_nuart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nuart_tx_sched
// Purpose  : Self-checking bench for nuart_tx_sched. Per-requester item
//            queues drive the request ports; expected grants and frames are
//            queued when stimulus is issued and popped by a handshake
//            monitor and a serial-line frame decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_nuart_tx_sched;

  localparam int NUM_REQ   = 4;
  localparam int IDX_W     = 2;
  localparam int STOP_BITS = 1;

  logic                 clk;
  logic                 rst_i;
  logic                 tx_timing_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 txd_o;
  logic [IDX_W-1:0]     grant_idx_o;
  logic                 locked_o;
  logic                 busy_o;

  nuart_tx_sched #(
    .NUM_REQ   (NUM_REQ),
    .IDX_W     (IDX_W),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tx_timing_i (tx_timing_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .txd_o       (txd_o),
    .grant_idx_o (grant_idx_o),
    .locked_o    (locked_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         dly;
  } item_t;

  typedef struct {
    logic [7:0] data;
    int         gap;   // required idle bits before this frame, -1 = any
  } frame_t;

  item_t  req_q [NUM_REQ][$];
  frame_t exp_frames[$];
  int     exp_grants[$];

  int checks = 0;
  int passed = 0;
  int mon_state = 0;   // 0 idle, 1 data, 2 parity, 3 stop
  int mon_bits  = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Clock and baud strobe (one cycle high every 10 clocks)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_timing_i = 1'b0;
    forever begin
      repeat (9) @(posedge clk);
      #1 tx_timing_i = 1'b1;
      @(posedge clk);
      #1 tx_timing_i = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Request driver and grant monitor
  // --------------------------------------------------------------------------
  initial begin : driver
    logic [NUM_REQ-1:0] hs;
    bit                 rst_now;
    int                 dly_cnt [NUM_REQ];
    bit                 started [NUM_REQ];
    int                 eg;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      dly_cnt[k] = 0;
      started[k] = 0;
    end
    forever begin
      @(negedge clk);
      hs      = req_valid_i & req_ready_o;
      rst_now = rst_i;
      @(posedge clk);
      #1;
      if (!rst_now && hs != '0) begin
        check($countones(hs) == 1, "ready_onehot", hs, 32'h1);
        for (int k = 0; k < NUM_REQ; k++) begin
          if (hs[k]) begin
            if (exp_grants.size() == 0) begin
              check(1'b0, "unexpected_grant", k, 0);
            end else begin
              eg = exp_grants.pop_front();
              check(k == eg, "grant_order", k, eg);
              check(grant_idx_o == IDX_W'(eg), "grant_idx", grant_idx_o, eg);
            end
            void'(req_q[k].pop_front());
            started[k] = 0;
          end
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_q[k].size() == 0) begin
          req_valid_i[k] = 1'b0;
        end else begin
          if (!started[k]) begin
            started[k] = 1;
            dly_cnt[k] = req_q[k][0].dly;
          end
          if (dly_cnt[k] > 0) begin
            dly_cnt[k]--;
            req_valid_i[k] = 1'b0;
          end else begin
            req_valid_i[k]        = 1'b1;
            req_data_i[8*k +: 8]  = req_q[k][0].data;
            req_last_i[k]         = req_q[k][0].last;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serial-line monitor: samples txd one time unit after each strobe edge.
  // --------------------------------------------------------------------------
  initial begin : line_mon
    int         gap;
    int         sc;
    logic [7:0] d;
    bit         ok;
    frame_t     e;
    gap = 0; sc = 0; d = '0; ok = 1;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        mon_state = 0;
        gap       = 0;
      end else if (tx_timing_i) begin
        #1;
        case (mon_state)
          0: begin
            if (!txd_o) begin
              mon_state = 1; mon_bits = 0; d = '0; ok = 1;
            end else begin
              gap++;
            end
          end
          1: begin
            d = {txd_o, d[7:1]};
            mon_bits++;
            if (mon_bits == 8) begin
              sc = 0;
`ifdef NUART_PARITY_EN
              mon_state = 2;
`else
              mon_state = 3;
`endif
            end
          end
          2: begin
            ok &= (txd_o == ^d);
            mon_state = 3;
          end
          default: begin
            ok &= (txd_o == 1'b1);
            sc++;
            if (sc == STOP_BITS) begin
              if (exp_frames.size() == 0) begin
                check(1'b0, "unexpected_frame", d, 0);
              end else begin
                e = exp_frames.pop_front();
                check(d == e.data, "frame_data", d, e.data);
                check(ok, "frame_format", ok, 1);
                if (e.gap >= 0) check(gap == e.gap, "frame_gap", gap, e.gap);
              end
              gap = 0;
              mon_state = 0;
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic push_item(input int k, input logic [7:0] d, input logic l, input int dly);
    item_t it;
    it.data = d; it.last = l; it.dly = dly;
    req_q[k].push_back(it);
  endtask

  task automatic exp_frame(input logic [7:0] d, input int gap);
    frame_t f;
    f.data = d; f.gap = gap;
    exp_frames.push_back(f);
  endtask

  function automatic bit all_drained();
    bit r;
    r = (exp_frames.size() == 0) && (exp_grants.size() == 0) && (mon_state == 0);
    for (int k = 0; k < NUM_REQ; k++) if (req_q[k].size() != 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (all_drained() && !busy_o) done = 1;
    end
    check(done, name, done, 1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin : main
    bit found;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(txd_o == 1'b1,      "rst_txd",    txd_o,       1);
    check(req_ready_o == '0,  "rst_ready",  req_ready_o, 0);
    check(grant_idx_o == '0,  "rst_grant",  grant_idx_o, 0);
    check(locked_o == 1'b0,   "rst_locked", locked_o,    0);
    check(busy_o == 1'b0,     "rst_busy",   busy_o,      0);
    rst_i = 1'b0;

    // T1: single byte 0xA5 from req0
    exp_grants.push_back(0);
    exp_frame(8'hA5, -1);
    push_item(0, 8'hA5, 1'b1, 0);
    repeat (30) @(negedge clk);
    check(busy_o == 1'b1, "t1_busy_mid", busy_o, 1);
    wait_idle(400, "t1_drain");
    check(busy_o == 1'b0, "t1_busy_end", busy_o, 0);

    // T2: 3-byte packet from req1 while req2 waits
    exp_grants.push_back(1); exp_grants.push_back(1);
    exp_grants.push_back(1); exp_grants.push_back(2);
    exp_frame(8'h11, -1); exp_frame(8'h22, 0);
    exp_frame(8'h33, 0);  exp_frame(8'h44, 0);
    push_item(1, 8'h11, 1'b0, 0);
    push_item(1, 8'h22, 1'b0, 0);
    push_item(1, 8'h33, 1'b1, 0);
    push_item(2, 8'h44, 1'b1, 0);
    repeat (5) @(negedge clk);
    check(locked_o == 1'b1,       "t2_locked",   locked_o,       1);
    check(req_ready_o[2] == 1'b0, "t2_r2_ready", req_ready_o[2], 0);
    wait_idle(800, "t2_drain");

    // T3: all four requesters, single-byte packets, from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        exp_grants.push_back(k);
        exp_frame(8'(8'h30 + 8'h10 * r + k), (r == 0 && k == 0) ? -1 : 0);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      push_item(k, 8'(8'h30 + k), 1'b1, 0);
      push_item(k, 8'(8'h40 + k), 1'b1, 0);
    end
    wait_idle(1500, "t3_drain");

    // T4: req1 locks, stalls 200 clocks; req3 must wait
    exp_grants.push_back(1); exp_grants.push_back(1); exp_grants.push_back(3);
    exp_frame(8'h55, -1); exp_frame(8'h66, -1); exp_frame(8'h77, 0);
    push_item(1, 8'h55, 1'b0, 0);
    push_item(1, 8'h66, 1'b1, 200);
    push_item(3, 8'h77, 1'b1, 0);
    repeat (60) @(negedge clk);
    check(locked_o == 1'b1,       "t4_locked",   locked_o,       1);
    check(req_ready_o[3] == 1'b0, "t4_r3_ready", req_ready_o[3], 0);
    repeat (100) @(negedge clk);
    check(txd_o == 1'b1,          "t4_line_idle", txd_o,         1);
    check(grant_idx_o == 2'd1,    "t4_owner",    grant_idx_o,    1);
    wait_idle(1000, "t4_drain");

    // T5: reset during data bit 4 of 0xF0
    exp_grants.push_back(0);
    push_item(0, 8'hF0, 1'b0, 0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mon_state == 1 && mon_bits == 5) found = 1;
    end
    check(found, "t5_reach_bit4", found, 1);
    check(locked_o == 1'b1, "t5_locked_pre", locked_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check(txd_o == 1'b1,    "t5_rst_txd",    txd_o,    1);
    check(locked_o == 1'b0, "t5_rst_locked", locked_o, 0);
    check(busy_o == 1'b0,   "t5_rst_busy",   busy_o,   0);
    rst_i = 1'b0;
    exp_grants.push_back(0);
    exp_frame(8'h0F, -1);
    push_item(0, 8'h0F, 1'b1, 0);
    wait_idle(400, "t5_drain");

`ifdef NUART_PARITY_EN
    // T6: parity frames (0x07 -> parity 1, 0x03 -> parity 0)
    exp_grants.push_back(0); exp_grants.push_back(0);
    exp_frame(8'h07, -1); exp_frame(8'h03, 0);
    push_item(0, 8'h07, 1'b1, 0);
    push_item(0, 8'h03, 1'b1, 0);
    wait_idle(600, "t6_drain");
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_nuart_tx_sched
`default_nettype wire
